imem_fetch_ctrl: RTL and testbench

IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

---
 rtl/imem_fetch_ctrl.sv | 138 +++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: assembles a 32-bit little-endian word from four
// byte reads of a 1-cycle-latency memory, holds it for the consumer, handles redirects and faults.
module imem_fetch_ctrl #(
  parameter int unsigned MEM_BYTES = 1024,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fault,
  output logic [1:0]  fault_code
);

  localparam logic [31:0] MaxPc      = 32'(MEM_BYTES - 4);
  localparam logic [2:0]  LastCnt    = 3'd4;
  localparam logic [1:0]  CodeBounds = 2'b01;
  localparam logic [1:0]  CodeAlign  = 2'b10;

  typedef enum logic [1:0] {StFetch, StHold, StFault} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  code_q, code_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic [31:0] addr_q;

  logic redirect_ok, redirect_bad, out_of_bounds, issue, capture;

  assign redirect_ok   = redirect && (redirect_pc[1:0] == 2'b00);
  assign redirect_bad  = redirect && (redirect_pc[1:0] != 2'b00);
  // Bounds are checked only before beat 0; pc is constant for the rest of the fetch.
  assign out_of_bounds = (state_q == StFetch) && (cnt_q == 3'd0) && (pc_q > MaxPc);
  assign issue         = !reset && (state_q == StFetch) && (cnt_q < LastCnt) && !out_of_bounds;
  // Beat k's byte arrives while cnt = k+1; a redirect discards whatever is in flight.
  assign capture       = (state_q == StFetch) && !redirect && (cnt_q != 3'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch: begin
        if (redirect_bad)                state_d = StFault;
        else if (redirect_ok)            state_d = StFetch;
        else if (out_of_bounds)          state_d = StFault;
        else if (cnt_q == LastCnt)       state_d = StHold;
      end
      StHold: begin
        if (redirect_bad)                state_d = StFault;
        else if (redirect_ok || instr_ready) state_d = StFetch;
      end
      StFault: state_d = StFault;
      default: state_d = StFault;
    endcase
  end

  always_comb begin
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    code_d     = code_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    if (state_q != StFault) begin
      if (redirect_bad) begin
        code_d = CodeAlign;
      end else if (redirect_ok) begin
        pc_d  = redirect_pc;
        cnt_d = 3'd0;
      end else if (state_q == StFetch) begin
        if (out_of_bounds) begin
          code_d = CodeBounds;
        end else if (cnt_q == LastCnt) begin
          cnt_d      = 3'd0;
          instr_pc_d = pc_q;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end else if (instr_ready) begin
        pc_d  = pc_q + 32'd4;
        cnt_d = 3'd0;
      end
    end
    if (capture) begin
      case (cnt_q)
        3'd1:    instr_d[7:0]   = mem_rdata;
        3'd2:    instr_d[15:8]  = mem_rdata;
        3'd3:    instr_d[23:16] = mem_rdata;
        3'd4:    instr_d[31:24] = mem_rdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      cnt_q      <= 3'd0;
      code_q     <= 2'b00;
      instr_q    <= 32'h0;
      instr_pc_q <= 32'h0;
      addr_q     <= 32'h0;
    end else begin
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      code_q     <= code_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      if (issue) addr_q <= mem_addr;
    end
  end

  always_comb begin
    mem_rd      = issue;
    mem_addr    = issue ? (pc_q + {29'b0, cnt_q}) : addr_q;
    instr_valid = (state_q == StHold);
    instr       = instr_q;
    instr_pc    = instr_pc_q;
    fault       = (state_q == StFault);
    fault_code  = code_q;
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios then random traffic, all outputs
// compared each cycle against a transaction-level fetch model and a byte memory.
module tb_imem_fetch_ctrl;

  localparam int unsigned MemBytes = 1024;
  localparam logic [31:0] ResetPc  = 32'h0;
  localparam logic [31:0] MaxPc    = 32'(MemBytes - 4);

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fault;
  logic [1:0]  fault_code;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [0:MemBytes-1];

  // Model: pc of the word being fetched/held, cycles since fetch start (5 = held).
  logic [31:0] m_pc;
  int          m_age;
  logic        m_fault;
  logic [1:0]  m_code;
  logic [31:0] m_last;

  imem_fetch_ctrl #(
    .MEM_BYTES(MemBytes),
    .RESET_PC (ResetPc)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .fault      (fault),
    .fault_code (fault_code)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_rd) mem_rdata <= mem[mem_addr[9:0]];
  end

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [9:0] b;
    b = a[9:0];
    return {mem[b + 10'd3], mem[b + 10'd2], mem[b + 10'd1], mem[b]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc    = ResetPc;
    m_age   = 0;
    m_fault = 1'b0;
    m_code  = 2'b00;
    m_last  = 32'h0;
  endtask

  // One clock cycle: drive inputs, compare all outputs, then advance the model at the edge.
  task automatic step(input logic r, input logic rdy, input logic rd, input logic [31:0] rp);
    logic exp_rd, exp_valid;
    logic [31:0] beat_addr;
    @(negedge clock);
    reset = r; instr_ready = rdy; redirect = rd; redirect_pc = rp;
    #1;
    beat_addr = m_pc + 32'(m_age);
    exp_rd    = !r && !m_fault && (m_age < 4) && !(m_age == 0 && m_pc > MaxPc);
    exp_valid = !m_fault && (m_age == 5);
    chk("mem_rd", {31'b0, mem_rd}, {31'b0, exp_rd});
    chk("mem_addr", mem_addr, exp_rd ? beat_addr : m_last);
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, exp_valid});
    chk("fault", {31'b0, fault}, {31'b0, m_fault});
    chk("fault_code", {30'b0, fault_code}, {30'b0, m_code});
    if (exp_valid) begin
      chk("instr", instr, word_at(m_pc));
      chk("instr_pc", instr_pc, m_pc);
    end
    @(posedge clock);
    if (r) begin
      model_reset();
    end else begin
      if (exp_rd) m_last = beat_addr;
      if (!m_fault) begin
        if (rd) begin
          if (rp[1:0] != 2'b00) begin
            m_fault = 1'b1; m_code = 2'b10;
          end else begin
            m_pc = rp; m_age = 0;
          end
        end else if (m_age == 0 && m_pc > MaxPc) begin
          m_fault = 1'b1; m_code = 2'b01;
        end else if (m_age == 5) begin
          if (rdy) begin
            m_pc = m_pc + 32'd4; m_age = 0;
          end
        end else begin
          m_age++;
        end
      end
    end
  endtask

  initial begin
    logic [7:0]  rnd8;
    logic [31:0] rp;
    logic        r, rd, rdy;
    int          sel;

    for (int i = 0; i < int'(MemBytes); i++) mem[i] = 8'($urandom);
    mem[0] = 8'h13; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h20;

    reset = 1'b1; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    repeat (3) @(posedge clock);
    model_reset();
    #2;
    chk("rst_mem_rd", {31'b0, mem_rd}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_fault", {29'b0, fault, fault_code}, 32'd0);

    // First word: bytes 0..3 issued on consecutive cycles, valid at cycle 5.
    repeat (5) step(1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    chk("first_valid", {31'b0, instr_valid}, 32'd1);
    chk("first_instr", instr, 32'h2000_0013);
    chk("first_pc", instr_pc, 32'h0);

    // Stall for 10 cycles, then accept; the next fetch starts at 4.
    repeat (10) step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    #2;
    chk("after_accept_addr", mem_addr, 32'h4);

    // Redirect to 0x40 during beat 2.
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h40);
    #2;
    chk("redir_addr", mem_addr, 32'h40);
    chk("redir_rd", {31'b0, mem_rd}, 32'd1);
    repeat (5) step(1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    chk("redir_word_pc", instr_pc, 32'h40);

    // Accept and redirect together: jump to 0x100, never 0x44.
    step(1'b0, 1'b1, 1'b1, 32'h100);
    #2;
    chk("accept_redir_addr", mem_addr, 32'h100);
    repeat (5) step(1'b0, 1'b0, 1'b0, 32'h0);

    // Misaligned redirect faults with code 10 and stops reads.
    step(1'b0, 1'b0, 1'b1, 32'h3FE);
    #2;
    chk("misalign_fault", {29'b0, fault, fault_code}, 32'b110);
    repeat (3) step(1'b0, 1'b0, 1'b1, 32'h8);

    // Reset out of FAULT, then fetch the last legal word.
    step(1'b1, 1'b0, 1'b0, 32'h0);
    #2;
    chk("fault_cleared", {31'b0, fault}, 32'd0);
    step(1'b0, 1'b0, 1'b1, 32'h3FC);
    repeat (5) step(1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    chk("edge_word_pc", instr_pc, 32'h3FC);
    chk("edge_word", instr, word_at(32'h3FC));

    // Redirect past the end faults with code 01 before any read.
    step(1'b0, 1'b0, 1'b1, 32'h400);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    chk("oob_fault", {29'b0, fault, fault_code}, 32'b101);
    step(1'b1, 1'b0, 1'b0, 32'h0);

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      r   = ($urandom_range(0, 199) == 0) || (m_fault && $urandom_range(0, 7) == 0);
      rd  = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      sel = int'($urandom_range(0, 29));
      rnd8 = 8'($urandom);
      if (sel == 0)      rp = {22'b0, rnd8, 2'b10};
      else if (sel == 1) rp = 32'h400;
      else               rp = {22'b0, rnd8, 2'b00};
      step(r, rdy, rd, rp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
